nios_tone_gen: RTL and testbench
================================

NIOS_TONE_GEN -- requirements
Module: nios_tone_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent tone channels; legal range 1..8.
REQ-002 Parameter CNT_W, default 16, divisor and counter width in bits; legal range 2..32.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 address  input  4  Avalon-MM word address.
REQ-006 chipselect  input  1  Avalon-MM slave select.
REQ-007 write_n  input  1  Avalon-MM write strobe, active-low; a write occurs when chipselect=1 and write_n=0.
REQ-008 writedata  input  32  Avalon-MM write data.
REQ-009 readdata  output  32  Avalon-MM read data, combinational from address, zero wait states.
REQ-010 tone_out  output  NUM_CH  square-wave output, one bit per channel.

Function
REQ-011 Register map SHALL be as follows; any other address reads 0 and ignores writes:
- 0 = CTRL, bits [NUM_CH-1:0] are channel enables.
- 1..NUM_CH = DIV[ch-1], half-period in clk cycles, writedata[CNT_W-1:0].
- NUM_CH+1 = STATUS, read-only, returns tone_out.
REQ-012 Readback SHALL zero-extend to 32 bits; DIV readback returns the last written value, not the active divisor.
REQ-013 Each channel SHALL hold a counter cnt (CNT_W bits) and an active divisor act_div.
REQ-014 When enabled and act_div>=1:
- cnt SHALL increment every cycle.
- When cnt >= act_div-1: cnt <= 0 and tone_out[ch] toggles.
- Half-period = act_div cycles.
REQ-015 act_div=1 SHALL toggle every cycle; act_div=0 SHALL stop the channel: cnt=0, tone_out[ch]=0.
REQ-016 Timing of the enable edge:
- A CTRL write at edge N setting an enable SHALL start counting from cnt=0 at edge N+1.
- The first rising edge of tone_out appears at edge N+act_div.
REQ-017 Clearing an enable SHALL force cnt=0 and tone_out[ch]=0 at the next edge, regardless of phase.
REQ-018 Channels SHALL be fully independent; a write to one DIV or enable bit SHALL NOT disturb the phase of any other channel.
REQ-019 The ">=" comparison SHALL guarantee wrap-around on the next cycle when a new divisor is smaller than the current cnt (no 2^CNT_W overflow run).

Reset
REQ-020 While reset_n=0 the block SHALL hold the following values; the first update SHALL occur on the first clk edge after release:
- CTRL=0.
- All DIV, act_div and cnt = 0.
- tone_out = 0.
- readdata reflects these zeros.

Configuration
REQ-021 Macro TONE_GEN_SHADOW_EN SHALL select how DIV writes take effect.
REQ-022 TONE_GEN_SHADOW_EN defined: a DIV write updates a pending register only, and act_div loads from pending at the next toggle of that channel, giving a glitch-free period change.
- If the channel is disabled or act_div=0, act_div loads on the edge after the write.
- If a write coincides with a toggle, the old pending value loads, and the new value loads at the following toggle.
REQ-023 TONE_GEN_SHADOW_EN undefined: act_div SHALL equal the written DIV from the edge after the write, and the current phase continues per REQ-019.

Verification
REQ-024 Reset: assert reset_n=0 mid-toggle with CTRL=0xF -> tone_out=0 immediately, every register reads 0.
REQ-025 Basic tone: DIV[0]=5, CTRL=0x1 -> tone_out[0] is a 10-cycle period square wave; first high at 5 cycles after the CTRL write edge; STATUS bit0 tracks it.
REQ-026 Independence: DIV[0]=3 and DIV[1]=7, both enabled; rewrite DIV[1]=2 -> channel 0 keeps its 6-cycle period with unchanged phase.
REQ-027 Shrink divisor: cnt=100 with DIV=200, write DIV=10.
- Shadow undefined -> wrap occurs on the next cycle.
- Shadow defined -> the 200-cycle half-period completes first, then 10-cycle half-periods follow.
REQ-028 Stop cases: DIV=0 with the channel enabled -> tone_out stays 0; disable mid-high -> low on the next edge; a read of address NUM_CH+2 -> 0.
REQ-029 Width rule: CNT_W=8, write DIV=0x1FF -> readback 0xFF, and half-period = 255 cycles.

Source files
------------

// File: rtl/nios_tone_gen.sv
// Avalon-MM controlled multi-channel square-wave tone generator.
// Define TONE_GEN_SHADOW_EN to defer divisor changes to the channel's next toggle.
module nios_tone_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] tone_out
);

  localparam logic [3:0]       STATUS_ADDR = 4'(NUM_CH + 1);
  localparam logic [CNT_W-1:0] ONE         = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              wr;
  logic [NUM_CH-1:0] ctrl;
  logic [NUM_CH-1:0] div_wr;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] wrap;
  logic [CNT_W-1:0]  div_reg [NUM_CH];
  logic [CNT_W-1:0]  act_div [NUM_CH];
  logic [CNT_W-1:0]  cnt     [NUM_CH];

  assign wr = chipselect & ~write_n;

  // ">=" rather than "==" so a divisor shrunk below cnt wraps immediately
  always_comb begin
    div_wr = '0;
    run    = '0;
    wrap   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      div_wr[i] = wr && (address == 4'(i + 1));
      run[i]    = ctrl[i] && (act_div[i] != '0);
      wrap[i]   = cnt[i] >= (act_div[i] - ONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= '0;
      tone_out <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_reg[i] <= '0;
        act_div[i] <= '0;
        cnt[i]     <= '0;
      end
    end else begin
      if (wr && address == 4'd0)
        ctrl <= writedata[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (div_wr[i])
          div_reg[i] <= writedata[CNT_W-1:0];
        if (!run[i]) begin
          cnt[i]      <= '0;
          tone_out[i] <= 1'b0;
        end else if (wrap[i]) begin
          cnt[i]      <= '0;
          tone_out[i] <= ~tone_out[i];
        end else begin
          cnt[i] <= cnt[i] + ONE;
        end
`ifdef TONE_GEN_SHADOW_EN
        // Pending value is taken at a half-period boundary, or at once when idle
        if (!run[i] || wrap[i])
          act_div[i] <= div_reg[i];
`else
        if (div_wr[i])
          act_div[i] <= writedata[CNT_W-1:0];
`endif
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (address == 4'd0) begin
      readdata[NUM_CH-1:0] = ctrl;
    end else if (address == STATUS_ADDR) begin
      readdata[NUM_CH-1:0] = tone_out;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (address == 4'(i + 1))
          readdata[CNT_W-1:0] = div_reg[i];
    end
  end

endmodule

// File: tb/tb_nios_tone_gen.sv
// Randomized and directed bench for nios_tone_gen against a half-period model.
module tb_nios_tone_gen;

  localparam int NCH = 4;
  localparam logic [31:0] MASK = 32'h0000FFFF;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [3:0]      address = '0;
  logic            chipselect = 1'b0;
  logic            write_n = 1'b1;
  logic [31:0]     writedata = '0;
  logic [31:0]     readdata, readdata8;
  logic [NCH-1:0]  tone_out, tone8;

  nios_tone_gen #(.NUM_CH(NCH), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .tone_out(tone_out));

  nios_tone_gen #(.NUM_CH(NCH), .CNT_W(8)) u8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata8), .tone_out(tone8));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model: per channel, written divisor, effective half-period, cycles elapsed in half, level
  int m_div [NCH];
  int m_act [NCH];
  int m_el  [NCH];
  bit m_en  [NCH];
  bit m_lvl [NCH];

  function automatic logic [NCH-1:0] m_tone();
    logic [NCH-1:0] t;
    for (int c = 0; c < NCH; c++) t[c] = m_lvl[c];
    return t;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r;
    r = '0;
    if (a == 0) begin
      for (int c = 0; c < NCH; c++) r[c] = m_en[c];
    end else if (a >= 1 && a <= NCH) begin
      r = 32'(m_div[a-1]);
    end else if (a == NCH + 1) begin
      r[NCH-1:0] = m_tone();
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_div[c] = 0; m_act[c] = 0; m_el[c] = 0; m_en[c] = 0; m_lvl[c] = 0;
    end
  endtask

  task automatic model_step(input bit we, input int a, input logic [31:0] d);
    bit idle, flip;
    int n_act;
    for (int c = 0; c < NCH; c++) begin
      idle = !m_en[c] || (m_act[c] == 0);
      flip = 0;
      n_act = m_act[c];
      if (idle) begin
        m_el[c] = 0;
        m_lvl[c] = 0;
      end else if (m_el[c] + 1 >= m_act[c]) begin
        m_el[c] = 0;
        m_lvl[c] = !m_lvl[c];
        flip = 1;
      end else begin
        m_el[c] = m_el[c] + 1;
      end
`ifdef TONE_GEN_SHADOW_EN
      if (idle || flip) n_act = m_div[c];
`else
      if (we && a == c + 1) n_act = int'(d & MASK);
`endif
      m_act[c] = n_act;
      if (we && a == c + 1) m_div[c] = int'(d & MASK);
    end
    if (we && a == 0)
      for (int c = 0; c < NCH; c++) m_en[c] = d[c];
  endtask

  task automatic tick(input bit cs, input bit wn, input int a, input logic [31:0] d);
    chipselect = cs;
    write_n = wn;
    address = 4'(a);
    writedata = d;
    @(posedge clk);
    model_step(cs && !wn, a, d);
    #1;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic wr_reg(input int a, input logic [31:0] d);
    tick(1'b1, 1'b0, a, d);
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b1, 0, 32'h0);
  endtask

  task automatic test_reset_initial();
    #3;
    if (tone_out !== '0) begin
      n_fail++; $display("FAIL init_tone: got %0h expected 0", tone_out);
    end
    n_checks++;
    for (int a = 0; a <= NCH + 2; a++) begin
      address = 4'(a);
      #1;
      if (readdata !== 32'h0) begin
        n_fail++; $display("FAIL init_read[%0d]: got %0h expected 0", a, readdata);
      end
      n_checks++;
    end
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    wr_reg(1, 2); wr_reg(2, 3); wr_reg(3, 4); wr_reg(4, 5);
    wr_reg(0, 32'hF);
    for (int k = 0; k < 7; k++) idle_tick();
    if (tone_out !== m_tone()) begin
      n_fail++; $display("FAIL pre_reset_tone: got %0h expected %0h", tone_out, m_tone());
    end
    n_checks++;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    if (tone_out !== '0) begin
      n_fail++; $display("FAIL reset_tone: got %0h expected 0", tone_out);
    end
    n_checks++;
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      if (readdata !== 32'h0 || readdata8 !== 32'h0) begin
        n_fail++; $display("FAIL reset_read[%0d]: got %0h/%0h expected 0", a, readdata, readdata8);
      end
      n_checks++;
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_basic_tone();
    logic exp;
    wr_reg(0, 0);
    wr_reg(1, 5);
    wr_reg(0, 1);
    for (int k = 1; k <= 40; k++) begin
      idle_tick();
      exp = ((k / 5) % 2) == 1;
      address = 4'(NCH + 1);
      #1;
      if (tone_out[0] !== exp || readdata[0] !== exp) begin
        n_fail++; $display("FAIL basic_k%0d: tone %0b status %0b expected %0b", k, tone_out[0], readdata[0], exp);
      end
      n_checks++;
    end
  endtask

  task automatic test_independence();
    logic exp;
    wr_reg(0, 0);
    wr_reg(1, 3);
    wr_reg(2, 7);
    wr_reg(0, 3);
    for (int k = 1; k <= 80; k++) begin
      if (k == 30) wr_reg(2, 2);
      else idle_tick();
      exp = ((k / 3) % 2) == 1;
      if (tone_out[0] !== exp || tone_out !== m_tone()) begin
        n_fail++; $display("FAIL indep_k%0d: got %0h ch0 expected %0b model %0h", k, tone_out, exp, m_tone());
      end
      n_checks++;
    end
  endtask

  task automatic test_shrink();
    int rise1, fall1;
`ifdef TONE_GEN_SHADOW_EN
    rise1 = 200; fall1 = 210;
`else
    rise1 = 102; fall1 = 112;
`endif
    wr_reg(0, 0);
    wr_reg(1, 200);
    wr_reg(0, 1);
    for (int k = 1; k <= 230; k++) begin
      if (k == 101) wr_reg(1, 10);
      else idle_tick();
      if (k == rise1 - 1 || k == rise1 || k == fall1 - 1 || k == fall1) begin
        if (tone_out[0] !== (k == rise1 || k == fall1 - 1)) begin
          n_fail++; $display("FAIL shrink_k%0d: got %0b expected %0b", k, tone_out[0], (k == rise1 || k == fall1 - 1));
        end
        n_checks++;
      end
      if (tone_out !== m_tone()) begin
        n_fail++; $display("FAIL shrink_model_k%0d: got %0h expected %0h", k, tone_out, m_tone());
      end
      n_checks++;
    end
  endtask

  task automatic test_stop();
    wr_reg(0, 0);
    wr_reg(1, 0);
    wr_reg(0, 1);
    for (int k = 0; k < 20; k++) begin
      idle_tick();
      if (tone_out[0] !== 1'b0) begin
        n_fail++; $display("FAIL div0_k%0d: got %0b expected 0", k, tone_out[0]);
      end
      n_checks++;
    end
    wr_reg(0, 0);
    wr_reg(1, 4);
    wr_reg(0, 1);
    for (int k = 1; k <= 4; k++) idle_tick();
    wr_reg(0, 0);
    if (tone_out[0] !== 1'b1) begin
      n_fail++; $display("FAIL disable_same_edge: got %0b expected 1", tone_out[0]);
    end
    n_checks++;
    idle_tick();
    if (tone_out[0] !== 1'b0) begin
      n_fail++; $display("FAIL disable_next_edge: got %0b expected 0", tone_out[0]);
    end
    n_checks++;
    wr_reg(NCH + 2, 32'hFFFF_FFFF);
    wr_reg(15, 32'h1234_5678);
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      if (readdata !== m_read(a)) begin
        n_fail++; $display("FAIL stop_read[%0d]: got %0h expected %0h", a, readdata, m_read(a));
      end
      n_checks++;
    end
  endtask

  task automatic test_random();
    int r, a, ra;
    logic [31:0] d;
    wr_reg(0, 0);
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 7);
      a = $urandom_range(0, NCH + 2);
      d = (a == 0) ? $urandom : 32'($urandom_range(0, 9)) | ($urandom & 32'hFFF0_0000);
      if (r == 0 || r == 1) tick(1'b1, 1'b0, a, d);
      else if (r == 2) tick(1'b1, 1'b1, a, d);
      else if (r == 3) tick(1'b0, 1'b0, a, d);
      else idle_tick();
      ra = $urandom_range(0, 15);
      address = 4'(ra);
      #1;
      if (tone_out !== m_tone()) begin
        n_fail++; $display("FAIL rand_tone_k%0d: got %0h expected %0h", k, tone_out, m_tone());
      end
      n_checks++;
      if (readdata !== m_read(ra)) begin
        n_fail++; $display("FAIL rand_read_k%0d a%0d: got %0h expected %0h", k, ra, readdata, m_read(ra));
      end
      n_checks++;
    end
  endtask

  task automatic test_width();
    int rise, fall;
    rise = -1; fall = -1;
    wr_reg(0, 0);
    wr_reg(1, 32'h1FF);
    address = 4'd1;
    #1;
    if (readdata8 !== 32'hFF || readdata !== 32'h1FF) begin
      n_fail++; $display("FAIL width_readback: got %0h/%0h expected ff/1ff", readdata8, readdata);
    end
    n_checks++;
    wr_reg(0, 1);
    for (int k = 1; k <= 600; k++) begin
      idle_tick();
      if (rise < 0 && tone8[0]) rise = k;
      if (rise >= 0 && !tone8[0]) begin
        fall = k;
        break;
      end
    end
    if (rise !== 255) begin
      n_fail++; $display("FAIL width_first_rise: got %0d expected 255", rise);
    end
    n_checks++;
    if (fall - rise !== 255) begin
      n_fail++; $display("FAIL width_half_period: got %0d expected 255", fall - rise);
    end
    n_checks++;
  endtask

  initial begin
    test_reset_initial();
    test_basic_tone();
    test_independence();
    test_shrink();
    test_stop();
    test_reset();
    test_random();
    test_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
